fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues imem reads, buffers returned words in a
//  small in-order queue, and feeds the IF/DC pipeline register (npc, instruction, enable).
//  Decouples imem latency from downstream stalls. Branch/jump redirects flush it.
// PARAMETERS
//  PC_INIT  32'h0000_0000  PC value loaded on reset
//  QDEPTH   2              fetch-queue entries; power of 2, >= 2
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  nRST           in   1   synchronous active-low reset
//  ihit           in   1   imem read complete; imemload valid this cycle
//  imemload       in   32  instruction word from imem
//  imemREN        out  1   imem read request
//  imemaddr       out  32  imem read address (= PC)
//  stall_i        in   1   IF/DC register cannot accept this cycle
//  redirect_i     in   1   taken branch/jump: flush and refetch
//  redirect_pc_i  in   32  new fetch PC when redirect_i = 1
//  halt_i         in   1   stop fetching (sticky until reset)
//  en_o           out  1   IF/DC register load enable
//  npc_o          out  32  PC+4 of delivered instruction
//  imemload_o     out  32  delivered instruction
// BEHAVIOUR
//  Reset (nRST=0 at edge): pc=PC_INIT, queue empty, state=FETCH. Combinational outputs
//   then read: imemREN=1, imemaddr=PC_INIT, en_o=0, npc_o=0, imemload_o=0.
//  FSM: FETCH, REDIR, HALTED.
//   FETCH : imemREN = (count < QDEPTH). On imemREN && ihit: push {pc+4, imemload}, pc<=pc+4.
//           redirect_i -> REDIR; halt_i -> HALTED (halt_i wins over redirect_i).
//   REDIR : one-cycle bubble, imemREN=0, no push; -> FETCH (-> HALTED if halt_i).
//   HALTED: imemREN=0, pc frozen, redirect_i ignored; exit only by reset.
//  Redirect (FETCH or REDIR): queue flushed, pc<=redirect_pc_i, ihit data that cycle
//   discarded, en_o forced 0 that cycle.
//  Delivery: en_o = (count>0) && !stall_i && !redirect_i; npc_o/imemload_o = queue head
//   (0 when empty); pop on en_o. Min latency: ihit in cycle N -> en_o in N+1.
//  Push+pop same cycle: count unchanged. Full: imemREN low, imemaddr held; no push.
//   Empty: en_o=0 regardless of stall_i.
//  imemaddr stable while imemREN=1 and ihit=0.
//  pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0. redirect_pc_i[1:0] ignored (forced 00).
//  Queue drains in HALTED; halt_i does not flush.
//  Reset mid-operation: queue, pc, FSM reinitialised same edge; in-flight ihit dropped.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs fetch_cnt_o[31:0] (+1 per push) and
//   stall_cnt_o[31:0] (+1 per cycle with count>0 && stall_i); both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset, ihit=1 every cycle, imemload=32'h2001_0001 -> imemaddr 0,4,8..; first en_o
//    one cycle after first ihit with npc_o=4, then 8, 12.
//  2 stall_i=1 for 4 cycles, ihit=1 -> queue fills (2), imemREN=0, imemaddr held 8;
//    release -> en_o two cycles, npc_o 4 then 8, fetching resumes at 8.
//  3 Queue full, redirect_i=1, redirect_pc_i=32'h100 -> en_o=0 that cycle, queue empty,
//    next cycle imemREN=0 (REDIR), following cycle imemaddr=32'h100.
//  4 redirect_i and ihit same cycle -> returned word never delivered; first npc_o after
//    redirect to 32'h200 is 32'h204.
//  5 halt_i with 1 queued entry -> imemREN=0 permanently, entry still delivered;
//    nRST low one cycle -> imemaddr=PC_INIT, fetching resumes.
//  6 Redirect to 32'hFFFF_FFFC, ihit -> npc_o=32'h0, next imemaddr=32'h0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem requests, in-order fetch queue feeding the IF/DC register.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          QDEPTH  = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
`endif
  output logic        en_o,
  output logic [31:0] npc_o,
  output logic [31:0] imemload_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, REDIR, HALTED} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [31:0]     r_pc;
  logic [31:0]     r_qNpc [QDEPTH];
  logic [31:0]     r_qIns [QDEPTH];
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;

  logic            w_redir;
  logic            w_push;
  logic            w_pop;
  logic            w_notEmpty;
  logic            w_notFull;
  logic [31:0]     w_redirPc;

  // A halted fetch unit ignores redirects entirely, including their flush.
  assign w_redir    = redirect_i && (r_state != HALTED);
  assign w_redirPc  = redirect_pc_i & ~32'h3;
  assign w_notEmpty = (r_count != '0);
  assign w_notFull  = (r_count < CW'(QDEPTH));

  assign imemREN    = (r_state == FETCH) && w_notFull;
  assign imemaddr   = r_pc;
  assign w_push     = imemREN && ihit && !w_redir;
  assign en_o       = w_notEmpty && !stall_i && !w_redir;
  assign w_pop      = en_o;
  assign npc_o      = w_notEmpty ? r_qNpc[r_rdPtr] : 32'h0;
  assign imemload_o = w_notEmpty ? r_qIns[r_rdPtr] : 32'h0;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH: begin
        if (halt_i)          w_nextState = HALTED;
        else if (redirect_i) w_nextState = REDIR;
      end
      REDIR:   w_nextState = halt_i ? HALTED : FETCH;
      HALTED:  w_nextState = HALTED;
      default: w_nextState = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_redir) begin
        r_pc    <= w_redirPc;
        r_rdPtr <= '0;
        r_wrPtr <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc    <= r_pc + 32'd4;
          r_wrPtr <= r_wrPtr + PW'(1);
        end
        if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Queue payload needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge CLK) begin
    if (w_push && nRST) begin
      r_qNpc[r_wrPtr] <= r_pc + 32'd4;
      r_qIns[r_wrPtr] <= imemload;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_stallCnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_fetchCnt <= '0;
      r_stallCnt <= '0;
    end else begin
      if (w_push)                r_fetchCnt <= r_fetchCnt + 32'd1;
      if (w_notEmpty && stall_i) r_stallCnt <= r_stallCnt + 32'd1;
    end
  end

  assign fetch_cnt_o = r_fetchCnt;
  assign stall_cnt_o = r_stallCnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int          QDEPTH  = 2;
  localparam logic [31:0] L       = 32'h2001_0001;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall_i, redirect_i, halt_i;
  logic [31:0] imemload, redirect_pc_i;
  logic        imemREN, en_o;
  logic [31:0] imemaddr, npc_o, imemload_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
  logic [31:0] sFetch, sStall, mFetch, mStall;
`endif

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(PC_INIT), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .en_o(en_o), .npc_o(npc_o), .imemload_o(imemload_o)
  );

  int vecCount  = 0;
  int missCount = 0;

  // Reference model: a plain queue of delivered words plus the fetch PC and two mode flags.
  typedef struct {logic [31:0] npc; logic [31:0] ins;} entry_t;
  entry_t      mq[$];
  logic [31:0] mPc;
  bit          mHalted, mBubble;
  logic        mRen, mEn, mRedir;
  logic [31:0] mAddr, mNpc, mIns;

  logic        sRen, sEn;
  logic [31:0] sAddr, sNpc, sIns;

  typedef struct {
    bit rst; bit ih; bit st;
    bit eRen; logic [31:0] eAddr; bit eEn; logic [31:0] eNpc; logic [31:0] eIns;
  } vec_t;
  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelUpdate(input bit rst, input bit ih, input bit st, input bit rd,
                             input bit hl, input logic [31:0] rpc, input logic [31:0] ld);
    bit push;
    entry_t e;
    if (!rst) begin
      mq.delete();
      mPc = PC_INIT;
      mHalted = 0;
      mBubble = 0;
`ifdef FETCH_PERF_CNT_EN
      mFetch = 0;
      mStall = 0;
`endif
    end else begin
      push = mRen && ih && !mRedir;
`ifdef FETCH_PERF_CNT_EN
      if (push) mFetch++;
      if (mq.size() > 0 && st) mStall++;
`endif
      if (mRedir) begin
        mq.delete();
        mPc = rpc & ~32'h3;
      end else begin
        if (mEn) void'(mq.pop_front());
        if (push) begin
          e.npc = mPc + 32'd4;
          e.ins = ld;
          mq.push_back(e);
          mPc = mPc + 32'd4;
        end
      end
      if (!mHalted) begin
        if (hl) mHalted = 1;
        else if (mBubble) mBubble = 0;
        else if (rd) mBubble = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, sample outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input bit rst, input bit ih, input bit st, input bit rd,
                               input bit hl, input logic [31:0] rpc, input logic [31:0] ld);
    nRST = rst; ihit = ih; stall_i = st; redirect_i = rd; halt_i = hl;
    redirect_pc_i = rpc; imemload = ld;
    mRedir = rd && !mHalted;
    mRen   = !mHalted && !mBubble && (mq.size() < QDEPTH);
    mAddr  = mPc;
    mEn    = (mq.size() > 0) && !st && !mRedir;
    mNpc   = (mq.size() > 0) ? mq[0].npc : 32'h0;
    mIns   = (mq.size() > 0) ? mq[0].ins : 32'h0;
    #2;
    sRen = imemREN; sEn = en_o; sAddr = imemaddr; sNpc = npc_o; sIns = imemload_o;
`ifdef FETCH_PERF_CNT_EN
    sFetch = fetch_cnt_o; sStall = stall_cnt_o;
`endif
    @(posedge CLK);
    modelUpdate(rst, ih, st, rd, hl, rpc, ld);
    @(negedge CLK);
  endtask

  initial begin
    nRST = 0; ihit = 0; stall_i = 0; redirect_i = 0; halt_i = 0;
    redirect_pc_i = 0; imemload = 0;
    mPc = PC_INIT; mHalted = 0; mBubble = 0;
`ifdef FETCH_PERF_CNT_EN
    mFetch = 0; mStall = 0;
`endif
    @(negedge CLK);

    //                rst ih st  ren addr  en npc  ins
    vecs[0]  = '{0, 0, 0, 1, 0,  0, 0,  0};
    vecs[1]  = '{1, 1, 0, 1, 0,  0, 0,  0};
    vecs[2]  = '{1, 1, 0, 1, 4,  1, 4,  L};
    vecs[3]  = '{1, 1, 0, 1, 8,  1, 8,  L};
    vecs[4]  = '{1, 1, 0, 1, 12, 1, 12, L};
    vecs[5]  = '{0, 0, 0, 1, 16, 1, 16, L};
    vecs[6]  = '{1, 1, 1, 1, 0,  0, 0,  0};
    vecs[7]  = '{1, 1, 1, 1, 4,  0, 4,  L};
    vecs[8]  = '{1, 1, 1, 0, 8,  0, 4,  L};
    vecs[9]  = '{1, 1, 1, 0, 8,  0, 4,  L};
    vecs[10] = '{1, 0, 0, 0, 8,  1, 4,  L};
    vecs[11] = '{1, 0, 0, 1, 8,  1, 8,  L};
    vecs[12] = '{1, 0, 0, 1, 8,  0, 0,  0};

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ih, vecs[i].st, 0, 0, 0, L);
      checkOutput($sformatf("vec%0d.imemREN", i), 32'(sRen), 32'(vecs[i].eRen));
      checkOutput($sformatf("vec%0d.imemaddr", i), sAddr, vecs[i].eAddr);
      checkOutput($sformatf("vec%0d.en_o", i), 32'(sEn), 32'(vecs[i].eEn));
      checkOutput($sformatf("vec%0d.npc_o", i), sNpc, vecs[i].eNpc);
      checkOutput($sformatf("vec%0d.imemload_o", i), sIns, vecs[i].eIns);
    end

    // Redirect while the queue is full
    applyStimulus(1, 1, 1, 0, 0, 0, L);
    applyStimulus(1, 1, 1, 0, 0, 0, L);
    applyStimulus(1, 1, 0, 1, 0, 32'h100, L);
    checkOutput("redirFull.en_o", 32'(sEn), 0);
    checkOutput("redirFull.imemREN", 32'(sRen), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("redirBubble.imemREN", 32'(sRen), 0);
    checkOutput("redirBubble.en_o", 32'(sEn), 0);
    checkOutput("redirBubble.npc_o", sNpc, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("redirResume.imemREN", 32'(sRen), 1);
    checkOutput("redirResume.imemaddr", sAddr, 32'h100);

    // Redirect coincident with ihit drops the returned word
    applyStimulus(1, 1, 0, 1, 0, 32'h200, 32'hDEAD_BEEF);
    checkOutput("redirHit.en_o", 32'(sEn), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("redirHitBubble.imemREN", 32'(sRen), 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h1234_5678);
    checkOutput("redirHitFetch.imemaddr", sAddr, 32'h200);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("redirHitDeliver.en_o", 32'(sEn), 1);
    checkOutput("redirHitDeliver.npc_o", sNpc, 32'h204);
    checkOutput("redirHitDeliver.imemload_o", sIns, 32'h1234_5678);

    // Halt with one queued entry, then reset
    applyStimulus(1, 1, 1, 0, 0, 0, 32'hAAAA_0001);
    applyStimulus(1, 0, 1, 0, 1, 0, 0);
    checkOutput("halt.en_o", 32'(sEn), 0);
    checkOutput("halt.npc_o", sNpc, 32'h208);
    applyStimulus(1, 1, 0, 1, 0, 32'h300, 0);
    checkOutput("halted.imemREN", 32'(sRen), 0);
    checkOutput("halted.en_o", 32'(sEn), 1);
    checkOutput("halted.npc_o", sNpc, 32'h208);
    checkOutput("halted.imemload_o", sIns, 32'hAAAA_0001);
    checkOutput("halted.imemaddr", sAddr, 32'h208);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("haltedDrained.imemREN", 32'(sRen), 0);
    checkOutput("haltedDrained.en_o", 32'(sEn), 0);
    checkOutput("haltedDrained.imemaddr", sAddr, 32'h208);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("haltReset.imemREN", 32'(sRen), 1);
    checkOutput("haltReset.imemaddr", sAddr, PC_INIT);

    // PC wraps from the top of the address space; redirect low bits are ignored
    applyStimulus(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrapBubble.imemaddr", sAddr, 32'hFFFF_FFFC);
    checkOutput("wrapBubble.imemREN", 32'(sRen), 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0000_0005);
    checkOutput("wrapFetch.imemREN", 32'(sRen), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrapDeliver.en_o", 32'(sEn), 1);
    checkOutput("wrapDeliver.npc_o", sNpc, 32'h0);
    checkOutput("wrapDeliver.imemload_o", sIns, 32'h0000_0005);
    checkOutput("wrapDeliver.imemaddr", sAddr, 32'h0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 299) == 0, $urandom, $urandom);
      checkOutput($sformatf("rnd%0d.imemREN", c), 32'(sRen), 32'(mRen));
      checkOutput($sformatf("rnd%0d.imemaddr", c), sAddr, mAddr);
      checkOutput($sformatf("rnd%0d.en_o", c), 32'(sEn), 32'(mEn));
      checkOutput($sformatf("rnd%0d.npc_o", c), sNpc, mNpc);
      checkOutput($sformatf("rnd%0d.imemload_o", c), sIns, mIns);
    end

`ifdef FETCH_PERF_CNT_EN
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("perf.fetch_cnt_o", sFetch, mFetch);
    checkOutput("perf.stall_cnt_o", sStall, mStall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
